uncache_wbuf: RTL and testbench

- Uncached store buffer and load sequencer. Sits between the memory stage and the uncache read/write ports of the CPU AXI interface.
- Absorbs up to DEPTH uncached stores so the pipeline does not stall on each AXI write response.
- Drains stores one at a time, in order.
- Issues uncached loads only after all older stores have completed, which gives strong MMIO ordering.

---
 rtl/uncache_pkg.sv | 27 ++
 rtl/uncache_wbuf_if.sv | 35 +++
 rtl/uncache_wbuf_fifo.sv | 60 ++++++
 rtl/uncache_wbuf.sv | 148 ++++++++++++++
 tb/tb_uncache_wbuf.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uncache_pkg.sv
// Shared types for the uncached store buffer: the buffered write entry and
// the drain/load FSM state encodings.
package uncache_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    virt_t       addr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    uint32_t     data;
  } uncache_wr_entry_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_REQ  = 2'd1,
    D_RESP = 2'd2
  } wbuf_drain_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } wbuf_rd_state_t;

endpackage

// File: rtl/uncache_wbuf_if.sv
// Uncache read/write port bundle between the store buffer (master) and the
// CPU AXI interface (slave).
interface uncache_wbuf_if;
  import uncache_pkg::*;

  logic        uncache_wr_req;
  virt_t       uncache_wr_addr;
  logic [2:0]  uncache_wr_size;
  logic [3:0]  uncache_wr_wstrb;
  uint32_t     uncache_wr_data;
  logic        uncache_wr_rdy;
  logic        uncache_wr_bvalid;

  logic        uncache_rd_req;
  virt_t       uncache_rd_addr;
  logic [2:0]  uncache_rd_size;
  logic        uncache_rd_rdy;
  logic        uncache_ret_valid;
  uint32_t     uncache_ret_data;

  modport master (
    output uncache_wr_req, uncache_wr_addr, uncache_wr_size, uncache_wr_wstrb, uncache_wr_data,
    input  uncache_wr_rdy, uncache_wr_bvalid,
    output uncache_rd_req, uncache_rd_addr, uncache_rd_size,
    input  uncache_rd_rdy, uncache_ret_valid, uncache_ret_data
  );

  modport slave (
    input  uncache_wr_req, uncache_wr_addr, uncache_wr_size, uncache_wr_wstrb, uncache_wr_data,
    output uncache_wr_rdy, uncache_wr_bvalid,
    input  uncache_rd_req, uncache_rd_addr, uncache_rd_size,
    output uncache_rd_rdy, uncache_ret_valid, uncache_ret_data
  );

endinterface

// File: rtl/uncache_wbuf_fifo.sv
// Register FIFO of uncached write entries; also exports per-entry valid bits
// and word addresses so the top can compare a load against pending stores.
module wbuf_fifo
  import uncache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  uncache_wr_entry_t       push_entry,
  input  logic                    pop,
  output uncache_wr_entry_t       head,
  output logic [CNT_W-1:0]        count,
  output logic [DEPTH-1:0]        entry_vld,
  output logic [DEPTH-1:0][29:0]  entry_waddr
);

  uncache_wr_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] age;
    assign age            = PTR_W'(i) - rd_ptr_q;
    assign entry_vld[i]   = CNT_W'(age) < count_q;
    assign entry_waddr[i] = mem[i].addr[31:2];
  end

endmodule

// File: rtl/uncache_wbuf.sv
// Uncached store buffer and in-order load sequencer in front of the AXI uncache ports.
// Optional: define UNCACHE_WBUF_LD_BYPASS_EN to let non-conflicting loads pass pending stores.
module uncache_wbuf
  import uncache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_req,
  input  virt_t                st_addr,
  input  logic [2:0]           st_size,
  input  logic [3:0]           st_wstrb,
  input  uint32_t              st_data,
  output logic                 st_ready,
  input  logic                 ld_req,
  input  virt_t                ld_addr,
  input  logic [2:0]           ld_size,
  output logic                 ld_ready,
  output logic                 ld_valid,
  output uint32_t              ld_data,
  output logic                 wbuf_empty,
  uncache_wbuf_if.master       axi
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_drain_state_t drain_q, drain_d;
  wbuf_rd_state_t    rd_q, rd_d;

  logic                   push, pop, ld_accept, hit;
  uncache_wr_entry_t      push_entry, head;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [DEPTH-1:0]       entry_vld;
  logic [DEPTH-1:0][29:0] entry_waddr;

  virt_t      rd_addr_q, rd_addr_d;
  logic [2:0] rd_size_q, rd_size_d;
  logic       ld_valid_q, ld_valid_d;
  uint32_t    ld_data_q, ld_data_d;

  // Stores are held off while a load is in flight so program order is kept.
  assign st_ready   = !reset && (count < CNT_W'(DEPTH)) && (rd_q == R_IDLE);
  assign push       = st_req && st_ready;
  assign push_entry = '{addr: st_addr, size: st_size, wstrb: st_wstrb, data: st_data};
  assign pop        = (drain_q == D_RESP) && axi.uncache_wr_bvalid;
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_vld   (entry_vld),
    .entry_waddr (entry_waddr)
  );

  assign wbuf_empty = (count == '0) && (drain_q == D_IDLE);

  // The head stays in the FIFO until its response, so in-flight stores are covered.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_waddr[i] == ld_addr[31:2])) hit = 1'b1;
    end
  end

`ifdef UNCACHE_WBUF_LD_BYPASS_EN
  assign ld_ready = !reset && (rd_q == R_IDLE) && !st_req && !hit;
`else
  // An empty buffer never hits; both builds share the one compare path.
  assign ld_ready = !reset && (rd_q == R_IDLE) && !st_req && wbuf_empty && !hit;
`endif
  assign ld_accept = ld_req && ld_ready;

  always_comb begin
    drain_d = drain_q;
    unique case (drain_q)
      D_IDLE:  if (count != '0) drain_d = D_REQ;
      D_REQ:   if (axi.uncache_wr_rdy) drain_d = D_RESP;
      D_RESP:  if (axi.uncache_wr_bvalid) drain_d = (count_nxt != '0) ? D_REQ : D_IDLE;
      default: drain_d = D_IDLE;
    endcase
  end

  always_comb begin
    rd_d       = rd_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    unique case (rd_q)
      R_IDLE: begin
        if (ld_accept) begin
          rd_d      = R_REQ;
          rd_addr_d = ld_addr;
          rd_size_d = ld_size;
        end
      end
      R_REQ:  if (axi.uncache_rd_rdy) rd_d = R_RESP;
      R_RESP: begin
        if (axi.uncache_ret_valid) begin
          rd_d       = R_IDLE;
          ld_valid_d = 1'b1;
          ld_data_d  = axi.uncache_ret_data;
        end
      end
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_q    <= D_IDLE;
      rd_q       <= R_IDLE;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      drain_q    <= drain_d;
      rd_q       <= rd_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
    rd_size_q <= rd_size_d;
  end

  assign axi.uncache_wr_req   = (drain_q == D_REQ);
  assign axi.uncache_wr_addr  = head.addr;
  assign axi.uncache_wr_size  = head.size;
  assign axi.uncache_wr_wstrb = head.wstrb;
  assign axi.uncache_wr_data  = head.data;

  assign axi.uncache_rd_req   = (rd_q == R_REQ);
  assign axi.uncache_rd_addr  = rd_addr_q;
  assign axi.uncache_rd_size  = rd_size_q;

  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed bench for uncache_wbuf with a small scripted AXI uncache responder.
module tb_uncache_wbuf;
  import uncache_pkg::*;

`ifdef UNCACHE_WBUF_LD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic st_req, ld_req, st_ready, ld_ready, ld_valid, wbuf_empty;
  virt_t st_addr, ld_addr;
  logic [2:0] st_size, ld_size;
  logic [3:0] st_wstrb;
  uint32_t st_data, ld_data;

  uncache_wbuf_if axi();

  uncache_wbuf #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_wstrb(st_wstrb),
    .st_data(st_data), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_ready(ld_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .wbuf_empty(wbuf_empty),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  int ws = 0, rs = 0, bcnt = 0, tcnt = 0, b_dly = 3, ret_dly = 2;
  bit b_hold = 1'b0, ret_hold = 1'b0;
  uint32_t ret_val = '0;
  int nb = 0, nrd = 0, b_cycle = 0, r_cycle = 0;
  logic [31:0] wlog_addr[$], wlog_data[$];
  logic [3:0]  wlog_strb[$];
  logic [2:0]  wlog_size[$];
  logic [31:0] rlog_addr;
  logic [2:0]  rlog_size;

  // Scripted responder: rdy one cycle after req, response after a programmable delay.
  initial begin
    axi.uncache_wr_rdy = 0; axi.uncache_wr_bvalid = 0;
    axi.uncache_rd_rdy = 0; axi.uncache_ret_valid = 0; axi.uncache_ret_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      axi.uncache_wr_rdy = 0; axi.uncache_wr_bvalid = 0;
      axi.uncache_rd_rdy = 0; axi.uncache_ret_valid = 0; axi.uncache_ret_data = '0;
      if (reset) begin
        ws = 0; rs = 0;
      end else begin
        case (ws)
          0: if (axi.uncache_wr_req) ws = 1;
          1: begin
            axi.uncache_wr_rdy = 1;
            wlog_addr.push_back(axi.uncache_wr_addr);
            wlog_data.push_back(axi.uncache_wr_data);
            wlog_strb.push_back(axi.uncache_wr_wstrb);
            wlog_size.push_back(axi.uncache_wr_size);
            bcnt = b_dly; ws = 2;
          end
          default: begin
            if (bcnt > 0) bcnt--;
            if (bcnt == 0 && !b_hold) begin
              axi.uncache_wr_bvalid = 1; nb++; b_cycle = cyc; ws = 0;
            end
          end
        endcase
        case (rs)
          0: if (axi.uncache_rd_req) rs = 1;
          1: begin
            axi.uncache_rd_rdy = 1;
            rlog_addr = axi.uncache_rd_addr; rlog_size = axi.uncache_rd_size; nrd++;
            tcnt = ret_dly; rs = 2;
          end
          default: begin
            if (tcnt > 0) tcnt--;
            if (tcnt == 0 && !ret_hold) begin
              axi.uncache_ret_valid = 1; axi.uncache_ret_data = ret_val; r_cycle = cyc; rs = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    k = 0;
    st_req = 1; st_addr = a; st_data = d; st_wstrb = s; st_size = 3'd2;
    #1;
    while (!st_ready && k < 400) begin tick(); k++; end
    check("store_accept", st_ready, 1);
    tick();
    st_req = 0;
  endtask

  task automatic do_load(input logic [31:0] a);
    int k;
    k = 0;
    ld_req = 1; ld_addr = a; ld_size = 3'd2;
    #1;
    while (!ld_ready && k < 400) begin tick(); k++; end
    check("load_accept", ld_ready, 1);
    tick();
    ld_req = 0;
  endtask

  task automatic wait_ld_valid();
    int k;
    k = 0;
    while (!ld_valid && k < 400) begin tick(); k++; end
    check("ld_valid_seen", ld_valid, 1);
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (!wbuf_empty && k < 400) begin tick(); k++; end
    check("wbuf_drained", wbuf_empty, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nb0, r0, k, blk;
    st_req = 0; ld_req = 1; st_addr = '0; ld_addr = '0; st_size = '0; ld_size = '0;
    st_wstrb = '0; st_data = '0;
    reset = 1;
    tick(); tick();
    check("rst_wr_req", axi.uncache_wr_req, 0);
    check("rst_rd_req", axi.uncache_rd_req, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_wbuf_empty", wbuf_empty, 1);
    check("rst_st_ready", st_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    ld_req = 0; reset = 0;
    tick();

    // T1: single store, rdy +1, bvalid +3
    b_dly = 3; base = wlog_addr.size();
    do_store(32'h1FAF_0000, 32'hDEAD_BEEF, 4'hF);
    check("t1_busy", wbuf_empty, 0);
    check("t1_req_latency", axi.uncache_wr_req, 0);
    tick();
    check("t1_req", axi.uncache_wr_req, 1);
    wait_empty();
    check("t1_empty_after_b", cyc - b_cycle, 1);
    check("t1_nwr", wlog_addr.size() - base, 1);
    check("t1_addr", wlog_addr[base], 32'h1FAF_0000);
    check("t1_data", wlog_data[base], 32'hDEAD_BEEF);
    check("t1_strb", wlog_strb[base], 4'hF);
    check("t1_size", wlog_size[base], 3'd2);

    // T2: five back-to-back stores into a 4-deep buffer
    b_dly = 10; base = wlog_addr.size(); nb0 = nb;
    st_req = 1; st_wstrb = 4'hF; st_size = 3'd2;
    for (int i = 0; i < 4; i++) begin
      st_addr = 32'h1FAF_0100 + 32'(4 * i); st_data = 32'hA000_0000 + 32'(i);
      #1;
      check($sformatf("t2_ready%0d", i), st_ready, 1);
      tick();
    end
    st_addr = 32'h1FAF_0110; st_data = 32'hA000_0004;
    #1;
    check("t2_full", st_ready, 0);
    k = 0;
    while (!st_ready && k < 400) begin tick(); k++; end
    check("t2_fifth_ready", st_ready, 1);
    check("t2_after_first_pop", nb - nb0, 1);
    check("t2_no_full_bypass", axi.uncache_wr_bvalid, 0);
    tick();
    st_req = 0;
    wait_empty();
    check("t2_nwr", wlog_addr.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_addr%0d", i), wlog_addr[base + i], 32'h1FAF_0100 + 32'(4 * i));
      check($sformatf("t2_data%0d", i), wlog_data[base + i], 32'hA000_0000 + 32'(i));
    end
    b_dly = 3;

    // T3: load behind a store to the same address
    b_hold = 1; nb0 = nb; r0 = nrd; ret_val = 32'h1234_5678;
    do_store(32'h1FAF_F000, 32'h0BAD_F00D, 4'hF);
    ld_req = 1; ld_addr = 32'h1FAF_F000; ld_size = 3'd2;
    #1;
    blk = 0;
    for (int i = 0; i < 10; i++) begin
      if (ld_ready) blk++;
      tick();
    end
    check("t3_blocked", blk, 0);
    b_hold = 0;
    k = 0;
    while (!ld_ready && k < 400) begin tick(); k++; end
    check("t3_ready", ld_ready, 1);
    check("t3_after_b", nb - nb0, 1);
    tick();
    ld_req = 0;
    wait_ld_valid();
    check("t3_ld_data", ld_data, 32'h1234_5678);
    check("t3_vld_latency", cyc - r_cycle, 1);
    check("t3_nrd", nrd - r0, 1);
    check("t3_rd_addr", rlog_addr, 32'h1FAF_F000);
    check("t3_rd_size", rlog_size, 3'd2);
    tick();
    check("t3_pulse", ld_valid, 0);

    // T4: store and load requested together on an empty buffer
    ret_val = 32'hCAFE_F00D; nb0 = nb;
    st_req = 1; st_addr = 32'h1FAF_0020; st_data = 32'h1111_2222; st_wstrb = 4'hF;
    ld_req = 1; ld_addr = 32'h1FAF_0020; ld_size = 3'd2;
    #1;
    check("t4_st_first", st_ready, 1);
    check("t4_ld_held", ld_ready, 0);
    tick();
    st_req = 0;
    #1;
    check("t4_ld_wait", ld_ready, 0);
    k = 0;
    while (!ld_ready && k < 400) begin tick(); k++; end
    check("t4_ready", ld_ready, 1);
    check("t4_after_b", nb - nb0, 1);
    check("t4_empty", wbuf_empty, 1);
    tick();
    ld_req = 0;
    wait_ld_valid();
    check("t4_ld_data", ld_data, 32'hCAFE_F00D);

    // T5a: asynchronous reset while a load waits for data
    ret_hold = 1;
    do_load(32'h1FAF_0030);
    for (int i = 0; i < 5; i++) tick();
    check("t5a_pre_ld_data", ld_data, 32'hCAFE_F00D);
    #1; reset = 1; #1;
    check("t5a_ld_data", ld_data, 0);
    check("t5a_ld_valid", ld_valid, 0);
    check("t5a_rd_req", axi.uncache_rd_req, 0);
    check("t5a_ld_ready", ld_ready, 0);
    tick(); tick();
    ret_hold = 0; reset = 0;
    tick();

    // T5b: asynchronous reset while a store waits for its response
    b_hold = 1;
    do_store(32'h1FAF_0040, 32'h4040_4040, 4'hF);
    do_store(32'h1FAF_0044, 32'h4444_4444, 4'hF);
    do_store(32'h1FAF_0048, 32'h4848_4848, 4'hF);
    for (int i = 0; i < 6; i++) tick();
    check("t5b_busy", wbuf_empty, 0);
    #1; reset = 1; #1;
    check("t5b_empty", wbuf_empty, 1);
    check("t5b_wr_req", axi.uncache_wr_req, 0);
    check("t5b_st_ready", st_ready, 0);
    tick(); tick();
    b_hold = 0; reset = 0;
    tick();
    base = wlog_addr.size();
    do_store(32'h1FAF_0050, 32'h5A5A_A5A5, 4'h3);
    wait_empty();
    check("t5b_nwr", wlog_addr.size() - base, 1);
    check("t5b_addr", wlog_addr[base], 32'h1FAF_0050);
    check("t5b_data", wlog_data[base], 32'h5A5A_A5A5);
    check("t5b_strb", wlog_strb[base], 4'h3);

    // T6: load to a different word while a store is pending
    b_hold = 1; ret_val = 32'h0F0F_0F0F; nb0 = nb;
    do_store(32'h1FAF_0000, 32'h0000_0077, 4'hF);
    tick(); tick();
    ld_req = 1; ld_addr = 32'h1FAF_0010; ld_size = 3'd2;
    #1;
    check("t6_nohit_ready", ld_ready, 32'(BYP));
    if (!BYP) b_hold = 0;
    k = 0;
    while (!ld_ready && k < 400) begin tick(); k++; end
    check("t6_ready", ld_ready, 1);
    tick();
    ld_req = 0;
    wait_ld_valid();
    check("t6_ld_data", ld_data, 32'h0F0F_0F0F);
    check("t6_store_pending", wbuf_empty, 32'(!BYP));
`ifdef UNCACHE_WBUF_LD_BYPASS_EN
    ret_val = 32'h2222_3333;
    ld_req = 1; ld_addr = 32'h1FAF_0002;
    #1;
    blk = 0;
    for (int i = 0; i < 4; i++) begin
      if (ld_ready) blk++;
      tick();
    end
    check("t6_hit_blocked", blk, 0);
    b_hold = 0;
    k = 0;
    while (!ld_ready && k < 400) begin tick(); k++; end
    check("t6_hit_ready", ld_ready, 1);
    check("t6_hit_after_b", nb - nb0, 1);
    tick();
    ld_req = 0;
    wait_ld_valid();
    check("t6_hit_data", ld_data, 32'h2222_3333);
`endif
    b_hold = 0;
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
